dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 SHALL expose parameter LINES, default 16, meaning the number of direct-mapped one-word lines; legal values are powers of two from 4 to 256.
REQ-002 SHALL expose port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL expose port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL expose port cpu_addr, input, 32 bits: core byte address; bits [1:0] are ignored.
REQ-005 SHALL expose port cpu_re, input, 1 bit: core read request.
REQ-006 SHALL expose port cpu_we, input, 4 bits: core byte write enables; bit i covers cpu_din[8i+7:8i].
REQ-007 SHALL expose port cpu_din, input, 32 bits: core store data.
REQ-008 SHALL expose port cpu_dout, output, 32 bits: load data returned to the core.
REQ-009 SHALL expose port stall, output, 1 bit: core must hold its request and pipeline while high.
REQ-010 SHALL expose port mem_req_valid, output, 1 bit: backing-memory request valid.
REQ-011 SHALL expose port mem_req_rw, output, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL expose port mem_req_addr, output, 32 bits: word-aligned address with bits [1:0] = 0.
REQ-013 SHALL expose port mem_req_data, output, 32 bits: write data.
REQ-014 SHALL expose port mem_req_mask, output, 4 bits: write byte mask.
REQ-015 SHALL expose port mem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-016 SHALL expose port mem_resp_valid, input, 1 bit: read data valid.
REQ-017 SHALL expose port mem_resp_data, input, 32 bits: read return data.

Function
REQ-018 SHALL decode index = cpu_addr[IDX+1:2] and tag = cpu_addr[31:IDX+2], where IDX = log2(LINES).
REQ-019 SHALL capture a request (address, cpu_re, cpu_we, cpu_din) at the rising edge E when stall=0 and (cpu_re=1 or cpu_we is nonzero), and SHALL perform the lookup in the cycle after E.
REQ-020 SHALL treat a captured request with any cpu_we bit set as a store, even if cpu_re=1 (store priority).
REQ-021 SHALL, on a load hit, drive cpu_dout with the line word in the cycle after E and hold stall=0 in that cycle; hit latency is 1 cycle.
REQ-022 SHALL, on a load miss, raise stall combinationally in the cycle after E and enter RD_REQ.
REQ-023 SHALL use states IDLE, RD_REQ, RD_WAIT and WR_REQ, with stall = 1 in every state other than IDLE and in IDLE whenever the captured request is a miss or a store.
REQ-024 SHALL, in RD_REQ, drive mem_req_valid=1 and mem_req_rw=0 with the word address; when mem_req_ready=1 it SHALL move to RD_WAIT.
REQ-025 SHALL, in RD_WAIT, on mem_resp_valid=1 write mem_resp_data into the line, set the line's valid bit and tag, register mem_resp_data onto cpu_dout, and return to IDLE.
REQ-026 SHALL drop stall in the cycle after the RD_WAIT response is captured, with cpu_dout then holding the filled word.
REQ-027 SHALL make every store write-through and no-write-allocate.
REQ-028 SHALL, on a store hit, merge the enabled bytes into the line.
REQ-029 SHALL leave the line untouched on a store miss.
REQ-030 SHALL, for every store, enter WR_REQ with mem_req_valid=1, mem_req_rw=1, mem_req_data=cpu_din and mem_req_mask=cpu_we.
REQ-031 SHALL return from WR_REQ to IDLE on mem_req_ready=1, with stall low in the following cycle.
REQ-032 SHALL hold mem_req_addr, mem_req_data, mem_req_mask and mem_req_rw stable while mem_req_valid=1 and mem_req_ready=0.
REQ-033 SHALL ignore mem_resp_valid in every state except RD_WAIT.
REQ-034 SHALL, when mem_resp_valid and mem_req_ready both arrive in RD_REQ, accept only the ready and treat the response as not yet arrived.
REQ-035 SHALL hold cpu_dout at its last value during stores, stalls and idle cycles.
REQ-036 SHALL treat a request with cpu_re=0 and cpu_we=0 as no operation: no state change, stall=0.

Reset
REQ-037 SHALL, while reset=0, asynchronously force all valid bits to 0, state to IDLE, cpu_dout to 0, stall to 0, mem_req_valid to 0, mem_req_rw to 0, mem_req_addr to 0, mem_req_data to 0 and mem_req_mask to 0.
REQ-038 SHALL, on reset assertion in any state, abandon the in-flight transaction, leaving no line partially filled.
REQ-039 SHALL, after reset deassertion, ignore any late mem_resp_valid.
REQ-040 SHALL leave tag and data arrays unreset; only the valid bits define hit status.

Verification
REQ-041 SHALL be verified by a cold load: reset, load 0x0000_0040, memory ready after 2 cycles, response 0x1234_5678 after 3 more cycles -> stall=1 until the fill, then cpu_dout=0x1234_5678 with stall=0.
REQ-042 SHALL be verified by a load hit: repeat load 0x0000_0040 -> cpu_dout=0x1234_5678 one cycle later, no mem_req_valid, stall=0.
REQ-043 SHALL be verified by a store hit: cpu_we=4'b0010, cpu_din=0x0000_AB00 to 0x40 -> memory write with mask 0010; a later load returns 0x1234_AB78 with no memory read.
REQ-044 SHALL be verified by a conflict miss: with LINES=16, load 0x0000_0080 (index 0, new tag) -> memory read issued; the old line is replaced and a load of 0x40 misses again.
REQ-045 SHALL be verified by reset during RD_WAIT: assert reset, release, then pulse mem_resp_valid -> no fill, stall=0, and a load of 0x40 misses.
REQ-046 SHALL be verified by store-miss backpressure: store to 0x100 with mem_req_ready held low 5 cycles -> mem_req fields stable and stall=1 throughout; afterwards a load of 0x100 misses (no allocate).

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate data cache.
// One-cycle load hits; misses and stores go to backing memory over a valid/ready port.
module dcache_responder #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [31:0] r_dout;
  logic [3:0]  r_we;
  logic        r_pend;

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [IDX-1:0] w_idx;
  logic [TW-1:0]  w_tag;
  logic [31:0]    w_line;
  logic [31:0]    w_merged;
  logic           w_store;
  logic           w_hit;
  logic           w_lookup;
  logic           w_ld_hit;
  logic           w_st_hit;
  logic           w_fill;
  logic           w_done;
  logic           w_new;
  logic           w_stall;
  logic           w_unused;

  assign w_unused = ^cpu_addr[1:0];

  assign w_idx    = r_addr[IDX+1:2];
  assign w_tag    = r_addr[31:IDX+2];
  assign w_line   = r_data[w_idx];
  assign w_store  = |r_we;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lookup = (r_state == IDLE) && r_pend;
  assign w_ld_hit = w_lookup && !w_store && w_hit;
  assign w_st_hit = w_lookup && w_store && w_hit;
  assign w_fill   = (r_state == RD_WAIT) && mem_resp_valid;
  assign w_done   = w_fill || ((r_state == WR_REQ) && mem_req_ready);
  assign w_new    = cpu_re || (|cpu_we);

  always_comb begin
    w_merged = w_line;
    for (int i = 0; i < 4; i++) begin
      if (r_we[i]) begin
        w_merged[8*i +: 8] = r_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend && w_store) begin
          w_stall = 1'b1;
          w_next  = WR_REQ;
        end else if (r_pend && !w_hit) begin
          w_stall = 1'b1;
          w_next  = RD_REQ;
        end
      end
      RD_REQ: begin
        w_stall       = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        w_stall = 1'b1;
        if (mem_resp_valid) w_next = IDLE;
      end
      WR_REQ: begin
        w_stall       = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        if (mem_req_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign stall        = w_stall;
  assign mem_req_addr = mem_req_valid ? r_addr : 32'h0;
  assign mem_req_data = mem_req_rw ? r_din : 32'h0;
  assign mem_req_mask = mem_req_rw ? r_we : 4'h0;
  assign cpu_dout     = w_ld_hit ? w_line : r_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_addr  <= 32'h0;
      r_din   <= 32'h0;
      r_we    <= 4'h0;
      r_dout  <= 32'h0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (!w_stall) begin
        r_pend <= w_new;
        if (w_new) begin
          r_addr <= {cpu_addr[31:2], 2'b00};
          r_din  <= cpu_din;
          r_we   <= cpu_we;
        end
      end else if (w_done) begin
        r_pend <= 1'b0;
      end
      if (w_ld_hit) r_dout <= w_line;
      if (w_fill) begin
        r_dout         <= mem_resp_data;
        r_valid[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; r_valid alone decides hits.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_resp_data;
      r_tag[w_idx]  <= w_tag;
    end else if (w_st_hit) begin
      r_data[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a line/memory model drives
// per-cycle expectations checked on every falling edge.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_responder #(.LINES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int rd0;
  int wr0;

  logic        chk_on = 1'b0;
  logic        e_stall;
  logic        e_mv;
  logic        e_rw;
  logic [31:0] e_addr;
  logic [31:0] e_data;
  logic [3:0]  e_mask;
  logic [31:0] e_dout;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_line  [16];
  logic [31:0] m_dout;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++)
      if (we[i]) v[8*i +: 8] = din[8*i +: 8];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    e_stall = 1'b0;
    e_mv    = 1'b0;
    e_dout  = m_dout;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("stall", 32'(stall), 32'(e_stall));
        check("cpu_dout", cpu_dout, e_dout);
        check("mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
        if (e_mv) begin
          check("mem_req_rw", 32'(mem_req_rw), 32'(e_rw));
          check("mem_req_addr", mem_req_addr, e_addr);
          if (e_rw) begin
            check("mem_req_data", mem_req_data, e_data);
            check("mem_req_mask", 32'(mem_req_mask), 32'(e_mask));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (reset && mem_req_valid && mem_req_ready) begin
        if (mem_req_rw) n_wr++;
        else n_rd++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_load(input logic [31:0] a, input int nrdy,
                         input int nwait, input bit race);
    int unsigned ix;
    logic [25:0] tg;
    bit          hit;
    ix  = (a >> 2) & 15;
    tg  = a[31:6];
    hit = m_valid[ix] && (m_tag[ix] == tg);
    cpu_addr = a;
    cpu_re   = 1'b1;
    cpu_we   = 4'h0;
    quiet();
    step();
    cpu_re = 1'b0;
    if (hit) begin
      m_dout = m_line[ix];
      quiet();
      step();
      quiet();
    end else begin
      e_stall = 1'b1;
      e_mv    = 1'b0;
      step();
      e_mv   = 1'b1;
      e_rw   = 1'b0;
      e_addr = {a[31:2], 2'b00};
      repeat (nrdy) begin
        mem_req_ready = 1'b0;
        step();
      end
      mem_req_ready = 1'b1;
      if (race) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
      end
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      e_mv = 1'b0;
      repeat (nwait) step();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_rd(a);
      step();
      mem_resp_valid = 1'b0;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_line[ix]  = mem_rd(a);
      m_dout      = m_line[ix];
      quiet();
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] din, input int nrdy,
                          input bit also_re);
    int unsigned ix;
    logic [25:0] tg;
    ix = (a >> 2) & 15;
    tg = a[31:6];
    cpu_addr = a;
    cpu_we   = we;
    cpu_din  = din;
    cpu_re   = also_re;
    quiet();
    step();
    cpu_we  = 4'h0;
    cpu_re  = 1'b0;
    e_stall = 1'b1;
    e_mv    = 1'b0;
    if (m_valid[ix] && (m_tag[ix] == tg))
      m_line[ix] = merge(m_line[ix], din, we);
    mem[{a[31:2], 2'b00}] = merge(mem_rd(a), din, we);
    step();
    e_mv   = 1'b1;
    e_rw   = 1'b1;
    e_addr = {a[31:2], 2'b00};
    e_data = din;
    e_mask = we;
    repeat (nrdy) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h7777_7777;
      step();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    mem_req_ready = 1'b0;
    quiet();
  endtask

  initial begin
    reset          = 1'b0;
    cpu_addr       = 32'h0;
    cpu_re         = 1'b0;
    cpu_we         = 4'h0;
    cpu_din        = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    e_rw = 1'b0; e_addr = 32'h0; e_data = 32'h0; e_mask = 4'h0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_dout = 32'h0;
    mem[32'h40]  = 32'h1234_5678;
    mem[32'h80]  = 32'hCAFE_0080;
    mem[32'h100] = 32'h0BAD_F00D;
    quiet();
    chk_on = 1'b1;

    @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_dout", cpu_dout, 32'h0);
    check("rst_mv", 32'(mem_req_valid), 32'h0);
    check("rst_rw", 32'(mem_req_rw), 32'h0);
    check("rst_addr", mem_req_addr, 32'h0);
    check("rst_data", mem_req_data, 32'h0);
    check("rst_mask", 32'(mem_req_mask), 32'h0);
    step();
    reset = 1'b1;
    step();

    rd0 = n_rd;
    do_load(32'h0000_0040, 2, 2, 1'b0);
    check("cold_dout", cpu_dout, 32'h1234_5678);
    check("cold_reads", n_rd - rd0, 1);

    rd0 = n_rd;
    do_load(32'h0000_0040, 0, 0, 1'b0);
    check("hit_dout", cpu_dout, 32'h1234_5678);
    check("hit_reads", n_rd - rd0, 0);

    wr0 = n_wr;
    do_store(32'h0000_0040, 4'b0010, 32'h0000_AB00, 1, 1'b1);
    check("sthit_writes", n_wr - wr0, 1);
    rd0 = n_rd;
    do_load(32'h0000_0040, 0, 0, 1'b0);
    check("sthit_dout", cpu_dout, 32'h1234_AB78);
    check("sthit_reads", n_rd - rd0, 0);

    cpu_addr = 32'h0000_0040;
    quiet();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0;
    step();

    rd0 = n_rd;
    do_load(32'h0000_0080, 0, 1, 1'b1);
    check("conf_dout", cpu_dout, 32'hCAFE_0080);
    check("conf_reads", n_rd - rd0, 1);
    rd0 = n_rd;
    do_load(32'h0000_0040, 1, 0, 1'b0);
    check("conf_reload", cpu_dout, 32'h1234_AB78);
    check("conf_rereads", n_rd - rd0, 1);

    cpu_addr = 32'h0000_0080;
    cpu_re   = 1'b1;
    quiet();
    step();
    cpu_re  = 1'b0;
    e_stall = 1'b1;
    step();
    e_mv   = 1'b1;
    e_rw   = 1'b0;
    e_addr = 32'h0000_0080;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    e_mv = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_dout = 32'h0;
    quiet();
    step();
    reset = 1'b1;
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_5555;
    step();
    mem_resp_valid = 1'b0;
    step();
    check("rst_late_dout", cpu_dout, 32'h0);
    check("rst_late_stall", 32'(stall), 32'h0);
    rd0 = n_rd;
    do_load(32'h0000_0040, 0, 0, 1'b0);
    check("rst_miss_reads", n_rd - rd0, 1);

    wr0 = n_wr;
    do_store(32'h0000_0100, 4'b1111, 32'hA5A5_0100, 5, 1'b0);
    check("stmiss_writes", n_wr - wr0, 1);
    rd0 = n_rd;
    do_load(32'h0000_0100, 0, 0, 1'b0);
    check("stmiss_reads", n_rd - rd0, 1);
    check("stmiss_dout", cpu_dout, 32'hA5A5_0100);

    step();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
